// File: rtl/puf_sweep_ctrl_if.sv
// Bundle of the sweep controller's control, PUF-side and record-stream signals.
// The master modport is the controller; the slave modport is its environment.
interface puf_sweep_ctrl_if;
    // sweep control
    logic        start;
    logic        abort;
    logic [7:0]  chal_first;
    logic [7:0]  chal_last;
    logic        busy;
    logic        timeout_err;
    logic [11:0] ones_count;
    // ring-oscillator PUF side
    logic        puf_reset;
    logic [7:0]  puf_challenge;
    logic [7:0]  puf_response;
    logic        puf_done;
    // record stream
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_challenge;
    logic [7:0]  out_response;

    modport master (
        input  start, abort, chal_first, chal_last, puf_response, puf_done, out_ready,
        output busy, timeout_err, ones_count, puf_reset, puf_challenge,
               out_valid, out_challenge, out_response
    );

    modport slave (
        output start, abort, chal_first, chal_last, puf_response, puf_done, out_ready,
        input  busy, timeout_err, ones_count, puf_reset, puf_challenge,
               out_valid, out_challenge, out_response
    );
endinterface

// File: rtl/puf_sweep_ctrl.sv
// Sweeps an RO PUF over a challenge range: per challenge it pulses the PUF
// reset, waits (bounded) for the measurement, and emits one challenge/response
// record over a valid/ready stream while keeping a running popcount.
module puf_sweep_ctrl #(
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset_n,
    puf_sweep_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        WAIT = 3'd2,
        EMIT = 3'd3,
        NEXT = 3'd4
    } state_t;

    localparam logic [7:0]  RST_LAST = 8'(RST_CYCLES - 1);
    localparam logic [23:0] TO_LAST  = 24'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  chal_last_q;
    logic [7:0]  rst_cnt;
    logic [23:0] to_cnt;
    logic        puf_reset_q;
    logic [7:0]  puf_challenge_q;
    logic        out_valid_q;
    logic [7:0]  out_challenge_q;
    logic [7:0]  out_response_q;
    logic        timeout_err_q;
    logic [11:0] ones_count_q;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Sweep sequencer; every output except busy is registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            chal_last_q     <= '0;
            rst_cnt         <= '0;
            to_cnt          <= '0;
            puf_reset_q     <= 1'b0;
            puf_challenge_q <= '0;
            out_valid_q     <= 1'b0;
            out_challenge_q <= '0;
            out_response_q  <= '0;
            timeout_err_q   <= 1'b0;
            ones_count_q    <= '0;
        end else if (bus.abort && (state != IDLE)) begin
            // abort outranks the handshake: no record is counted this cycle
            state       <= IDLE;
            out_valid_q <= 1'b0;
            puf_reset_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        chal_last_q     <= bus.chal_last;
                        puf_challenge_q <= bus.chal_first;
                        timeout_err_q   <= 1'b0;
                        ones_count_q    <= '0;
                        rst_cnt         <= '0;
                        puf_reset_q     <= 1'b1;
                        state           <= ARM;
                    end
                end
                ARM: begin
                    if (rst_cnt == RST_LAST) begin
                        puf_reset_q <= 1'b0;
                        to_cnt      <= '0;
                        state       <= WAIT;
                    end else begin
                        rst_cnt <= rst_cnt + 8'd1;
                    end
                end
                WAIT: begin
                    if (bus.puf_done) begin
                        out_response_q  <= bus.puf_response;
                        out_challenge_q <= puf_challenge_q;
                        out_valid_q     <= 1'b1;
                        state           <= EMIT;
                    end else if (to_cnt == TO_LAST) begin
                        out_response_q  <= '0;
                        out_challenge_q <= puf_challenge_q;
                        timeout_err_q   <= 1'b1;
                        out_valid_q     <= 1'b1;
                        state           <= EMIT;
                    end else begin
                        to_cnt <= to_cnt + 24'd1;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        ones_count_q <= ones_count_q + {8'b0, popcount8(out_response_q)};
                        out_valid_q  <= 1'b0;
                        state        <= NEXT;
                    end
                end
                NEXT: begin
                    if (puf_challenge_q == chal_last_q) begin
                        state <= IDLE;
                    end else begin
                        puf_challenge_q <= puf_challenge_q + 8'd1;
                        rst_cnt         <= '0;
                        puf_reset_q     <= 1'b1;
                        state           <= ARM;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy          = (state != IDLE);
    assign bus.puf_reset     = puf_reset_q;
    assign bus.puf_challenge = puf_challenge_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_challenge = out_challenge_q;
    assign bus.out_response  = out_response_q;
    assign bus.timeout_err   = timeout_err_q;
    assign bus.ones_count    = ones_count_q;

endmodule

// File: tb/tb_puf_sweep_ctrl.sv
// Directed bench for puf_sweep_ctrl with a behavioural RO PUF and a record
// scoreboard: expected records are queued at START and popped on transfer.
module tb_puf_sweep_ctrl;

    localparam int RST = 4;
    localparam int TO  = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    puf_sweep_ctrl_if bus ();

    puf_sweep_ctrl #(.RST_CYCLES(RST), .TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q[$];
    int exp_ones = 0;

    // PUF model: done rises puf_dly cycles after its reset drops, then stays high
    logic puf_en  = 1'b1;
    int   puf_dly = 5;
    int   dly_cnt = 0;

    function automatic logic [7:0] puf_fn(input logic [7:0] c);
        logic [7:0] m;
        m = c * 8'd37;
        return m ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        if (bus.puf_reset) dly_cnt <= 0;
        else if (dly_cnt < puf_dly) dly_cnt <= dly_cnt + 1;
    end
    assign bus.puf_done     = puf_en && (dly_cnt == puf_dly);
    assign bus.puf_response = puf_fn(bus.puf_challenge);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transfer monitor and PUF-reset pulse width check
    int prs_len = 0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_record", {bus.out_challenge, bus.out_response}, 32'hFFFF_FFFF);
                end else begin
                    logic [15:0] r;
                    r = exp_q.pop_front();
                    chk("rec_chal", bus.out_challenge, r[15:8]);
                    chk("rec_resp", bus.out_response, r[7:0]);
                end
            end
            if (bus.puf_reset) prs_len++;
            else if (prs_len != 0) begin
                chk("puf_reset_len", prs_len, RST);
                prs_len = 0;
            end
        end
    end

    task automatic start_sweep(input logic [7:0] first, input logic [7:0] last, input int max_rec);
        logic [7:0] c;
        logic [7:0] r;
        int n;
        c = first;
        n = 0;
        exp_ones = 0;
        forever begin
            if (n >= max_rec) break;
            r = puf_en ? puf_fn(c) : 8'h00;
            exp_q.push_back({c, r});
            exp_ones += $countones(r);
            n++;
            if (c == last) break;
            c = c + 8'd1;
        end
        bus.chal_first = first;
        bus.chal_last  = last;
        bus.start      = 1'b1;
        step();
        bus.start      = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (bus.busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("busy_fall", bus.busy, 0);
    endtask

    task automatic wait_valid(input int budget);
        int k;
        k = 0;
        while (!bus.out_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("valid_seen", bus.out_valid, 1);
    endtask

    // Counts cycles spent between PUF reset falling and the record appearing
    task automatic count_wait(output int n);
        int k;
        k = 0;
        while (!bus.puf_reset && k < 50) begin @(negedge clk); k++; end
        while (bus.puf_reset && k < 100) begin @(negedge clk); k++; end
        n = 0;
        while (!bus.out_valid && n < 200) begin n++; @(negedge clk); end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_puf_reset"}, bus.puf_reset, 0);
        chk({tag, "_puf_chal"}, bus.puf_challenge, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_chal"}, bus.out_challenge, 0);
        chk({tag, "_out_resp"}, bus.out_response, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_terr"}, bus.timeout_err, 0);
        chk({tag, "_ones"}, bus.ones_count, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b0;
        bus.chal_first = '0; bus.chal_last = '0;
        #1 reset_n = 1'b0;
        #3 check_zero("reset");
        step(); step();
        @(negedge clk) reset_n = 1'b1;
        step();

        // 10..12, ready high, range inputs scribbled after START
        bus.out_ready = 1'b1;
        start_sweep(8'h10, 8'h12, 999);
        chk("busy_after_start", bus.busy, 1);
        chk("arm_puf_reset", bus.puf_reset, 1);
        chk("chal_loaded", bus.puf_challenge, 8'h10);
        bus.chal_first = 8'h00; bus.chal_last = 8'h20;
        wait_idle(400);
        chk("s1_queue_empty", exp_q.size(), 0);
        chk("s1_ones", bus.ones_count, exp_ones);
        chk("s1_terr", bus.timeout_err, 0);

        // FE..01 wraps; START while busy ignored
        start_sweep(8'hFE, 8'h01, 999);
        repeat (3) step();
        bus.chal_first = 8'h80; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("s2_chal_stable", bus.puf_challenge, 8'hFE);
        wait_idle(600);
        chk("s2_queue_empty", exp_q.size(), 0);
        chk("s2_ones", bus.ones_count, exp_ones);

        // timeout: PUF never finishes
        puf_en = 1'b0;
        start_sweep(8'h20, 8'h20, 999);
        count_wait(n);
        chk("to_wait_cycles", n, TO);
        wait_idle(100);
        chk("to_terr", bus.timeout_err, 1);
        repeat (5) step();
        chk("to_terr_sticky", bus.timeout_err, 1);
        chk("to_ones", bus.ones_count, 0);
        chk("to_queue_empty", exp_q.size(), 0);

        // done already high on first WAIT cycle
        puf_en = 1'b1; puf_dly = 0;
        start_sweep(8'h30, 8'h30, 999);
        chk("terr_cleared", bus.timeout_err, 0);
        count_wait(n);
        chk("d0_wait_cycles", n, 1);
        wait_idle(100);
        chk("d0_ones", bus.ones_count, exp_ones);

        // consumer stalls 10 cycles
        puf_dly = 5; bus.out_ready = 1'b0;
        start_sweep(8'h40, 8'h41, 999);
        chk("ones_cleared", bus.ones_count, 0);
        wait_valid(100);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_chal", bus.out_challenge, 8'h40);
            chk("stall_resp", bus.out_response, puf_fn(8'h40));
            chk("stall_puf_reset", bus.puf_reset, 0);
        end
        step();
        bus.out_ready = 1'b1;
        wait_idle(200);
        chk("stall_queue_empty", exp_q.size(), 0);
        chk("stall_ones", bus.ones_count, exp_ones);

        // ABORT with START during WAIT of the second challenge
        start_sweep(8'h50, 8'h53, 1);
        k = 0;
        while (!(bus.puf_challenge == 8'h51 && bus.busy && !bus.puf_reset) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("ab_reached_wait", bus.puf_challenge, 8'h51);
        step();
        bus.abort = 1'b1; bus.start = 1'b1; bus.chal_first = 8'h99;
        step();
        bus.abort = 1'b0; bus.start = 1'b0;
        chk("ab_busy", bus.busy, 0);
        chk("ab_valid", bus.out_valid, 0);
        chk("ab_puf_reset", bus.puf_reset, 0);
        repeat (20) step();
        chk("ab_still_idle", bus.busy, 0);
        chk("ab_queue_empty", exp_q.size(), 0);
        chk("ab_ones", bus.ones_count, exp_ones);

        // reset pulse in the middle of EMIT
        bus.out_ready = 1'b0;
        start_sweep(8'h60, 8'h61, 0);
        wait_valid(100);
        #2 reset_n = 1'b0;
        #1 check_zero("async_rst");
        exp_q.delete();
        @(negedge clk) reset_n = 1'b1;
        step();
        bus.out_ready = 1'b1;
        start_sweep(8'h70, 8'h70, 999);
        chk("post_rst_busy", bus.busy, 1);
        chk("post_rst_chal", bus.puf_challenge, 8'h70);
        wait_idle(100);
        chk("post_rst_queue_empty", exp_q.size(), 0);
        chk("post_rst_ones", bus.ones_count, exp_ones);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/puf_sweep_ctrl.md
PUF_SWEEP_CTRL -- requirements
Module: puf_sweep_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 4: number of cycles PUF_RESET is held high per challenge (legal 1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: maximum cycles to wait for PUF_DONE (legal 1..2^24-1).
REQ-003 CLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 START  in  1  single-cycle request to begin a sweep.
REQ-006 ABORT  in  1  terminates an active sweep.
REQ-007 CHAL_FIRST  in  8  first challenge of sweep.
REQ-008 CHAL_LAST  in  8  last challenge of sweep.
REQ-009 PUF_RESET  out  1  active-high reset to the RO PUF.
REQ-010 PUF_CHALLENGE  out  8  challenge presented to the RO PUF.
REQ-011 PUF_RESPONSE  in  8  PUF response, valid while PUF_DONE high.
REQ-012 PUF_DONE  in  1  PUF measurement complete.
REQ-013 OUT_VALID  out  1  record available.
REQ-014 OUT_READY  in  1  consumer accepts record.
REQ-015 OUT_CHALLENGE  out  8  challenge of current record.
REQ-016 OUT_RESPONSE  out  8  response of current record.
REQ-017 BUSY  out  1  high in any state other than IDLE.
REQ-018 TIMEOUT_ERR  out  1  sticky: at least one challenge of current sweep timed out.
REQ-019 ONES_COUNT  out  12  running popcount of all responses emitted in current sweep.

Function
REQ-020 FSM states SHALL be IDLE, ARM, WAIT, EMIT, NEXT.
REQ-021 IDLE: on START, latch CHAL_FIRST/CHAL_LAST, load PUF_CHALLENGE=CHAL_FIRST, clear TIMEOUT_ERR and ONES_COUNT, go ARM next cycle.
REQ-022 START while BUSY SHALL be ignored; CHAL_FIRST/CHAL_LAST changes mid-sweep SHALL have no effect.
REQ-023 ARM: PUF_RESET high for exactly RST_CYCLES consecutive cycles, then go WAIT with PUF_RESET low.
REQ-024 WAIT: timeout counter starts at 0 on entry; the first cycle PUF_DONE is high, capture PUF_RESPONSE and go EMIT.
REQ-025 WAIT: if counter reaches TIMEOUT_CYCLES with PUF_DONE low, capture response 8'h00, set TIMEOUT_ERR, go EMIT.
REQ-026 PUF_DONE seen high in the first WAIT cycle SHALL be accepted (no minimum wait).
REQ-027 EMIT: OUT_VALID high with OUT_CHALLENGE/OUT_RESPONSE stable until the cycle OUT_VALID and OUT_READY are both high; that cycle ONES_COUNT += popcount(OUT_RESPONSE), go NEXT.
REQ-028 OUT_VALID SHALL NOT depend combinationally on OUT_READY; OUT_READY held high gives one record per challenge with no extra stall.
REQ-029 NEXT (one cycle): if PUF_CHALLENGE==latched CHAL_LAST go IDLE, else PUF_CHALLENGE increments modulo 256 and go ARM.
REQ-030 CHAL_FIRST>CHAL_LAST SHALL wrap 255->0; CHAL_FIRST==CHAL_LAST SHALL produce exactly one record; 0..255 produces 256 records.
REQ-031 ONES_COUNT SHALL NOT overflow (max 256*8=2048 fits 12 bits).
REQ-032 ABORT in any non-IDLE state: next cycle state IDLE, OUT_VALID low, PUF_RESET low; no record transferred that cycle even if OUT_READY high; ABORT has priority over START and handshake.
REQ-033 TIMEOUT_ERR and ONES_COUNT SHALL hold their values in IDLE until next accepted START.
REQ-034 PUF_CHALLENGE SHALL remain stable throughout ARM, WAIT and EMIT.

Reset
REQ-035 RESET_N low SHALL immediately force state IDLE and all outputs to 0 (PUF_CHALLENGE 8'h00, ONES_COUNT 0, TIMEOUT_ERR 0), independent of CLK.
REQ-036 Reset assertion mid-sweep SHALL discard the sweep; first START after RESET_N release SHALL behave per REQ-021.

Verification
REQ-037 FIRST=8'h10, LAST=8'h12, PUF model DONE 5 cycles after PUF_RESET falls, OUT_READY=1 -> 3 records, challenges 10,11,12; PUF_RESET high 4 cycles each; BUSY falls after 3rd.
REQ-038 FIRST=8'hFE, LAST=8'h01 -> records FE,FF,00,01 in order; ONES_COUNT equals sum of response popcounts.
REQ-039 TIMEOUT_CYCLES=16, PUF_DONE held low -> record response 00 after 16 WAIT cycles, TIMEOUT_ERR=1 sticky to sweep end and through IDLE.
REQ-040 OUT_READY low 10 cycles during EMIT -> OUT_VALID and data stable all 10 cycles, single transfer, PUF_RESET not reasserted until after transfer.
REQ-041 ABORT during WAIT of 2nd challenge, START same cycle -> IDLE next cycle, BUSY=0, no record; RESET_N pulse mid-EMIT -> all outputs 0 asynchronously.
